// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide engine that backs the HI/LO registers.
// A single 2*WIDTH accumulator is shared by both operations. For MULT it is a
// shift-add over the multiplier bits. For DIV it performs restoring division,
// with the remainder in the upper half and the quotient shifting into the
// lower half. Signs are stripped in PREP and restored in FIX, so RUN only
// ever works on unsigned magnitudes.
module mult_div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPrep = 3'd1,
      StRun  = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } state_t;

   state_t state_q, state_d;

   // Operands and sign flags captured when a request is accepted
   logic             op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sign_q;   // product sign (MULT) or quotient sign (DIV)
   logic             rsign_q;  // remainder sign: follows the dividend
   logic             dz_q;

   // Iteration state
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   m_q;    // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q;

   // Architectural results
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   // Magnitudes; the wrap of -(-2^(W-1)) gives the correct unsigned value
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             b_is_zero;

   // One iteration of each algorithm
   logic [WIDTH:0]     mult_sum;
   logic [2*WIDTH-1:0] mult_acc;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_acc;
   logic [2*WIDTH-1:0] step_acc;

   // Sign-corrected results presented to HI/LO in FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   hi_fix;
   logic [WIDTH-1:0]   lo_fix;

   // Operand magnitudes and the divide-by-zero detect
   always_comb begin
      a_mag     = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
      b_mag     = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
      b_is_zero = (b_q == '0);
   end

   // Single shift-add / restoring-divide step on the shared accumulator
   always_comb begin
      // MULT: add the multiplicand into the upper half when the current
      // multiplier bit is set, then shift the whole accumulator right,
      // including the carry.
      if (acc_q[0]) begin
         mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
      end else begin
         mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      end
      mult_acc = {mult_sum, acc_q[WIDTH-1:1]};

      // DIV: shift the next dividend bit into a W+1 bit partial remainder,
      // so 2*rem+1 never overflows. The divisor is then subtracted only if
      // it fits.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, m_q});
      if (div_ge) begin
         div_rem = WIDTH'(div_shift - {1'b0, m_q});
      end else begin
         div_rem = div_shift[WIDTH-1:0];
      end
      div_acc = {div_rem, acc_q[WIDTH-2:0], div_ge};

      step_acc = op_q ? div_acc : mult_acc;
   end

   // Sign fix-up; all negations wrap mod 2^W (or 2^2W for the product)
   always_comb begin
      prod_fix = sign_q ? (~acc_q + 1'b1) : acc_q;
      quot_fix = sign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fix  = rsign_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      if (op_q) begin
         hi_fix = rem_fix;
         lo_fix = quot_fix;
      end else begin
         hi_fix = prod_fix[2*WIDTH-1:WIDTH];
         lo_fix = prod_fix[WIDTH-1:0];
      end
   end

   // Sequencer next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StPrep;
         // A divide by zero skips RUN and FIX, so HI/LO stay untouched
         StPrep: state_d = (op_q && b_is_zero) ? StDone : StRun;
         StRun:  if (cnt_q == CW'(1)) state_d = StFix;
         StFix:  state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      busy     = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
      done     = (state_q == StDone);
      div_zero = (state_q == StDone) && dz_q;
      hi       = hi_q;
      lo       = lo_q;
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         rsign_q <= 1'b0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= b;
                  sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                  rsign_q <= a[WIDTH-1];
                  dz_q    <= 1'b0;
               end
            end
            StPrep: begin
               cnt_q <= CW'(WIDTH);
               dz_q  <= op_q && b_is_zero;
               if (op_q) begin
                  // Dividend starts in the low half, remainder starts at zero
                  m_q   <= b_mag;
                  acc_q <= {{WIDTH{1'b0}}, a_mag};
               end else begin
                  // Multiplier starts in the low half and is consumed LSB first
                  m_q   <= a_mag;
                  acc_q <= {{WIDTH{1'b0}}, b_mag};
               end
            end
            StRun: begin
               cnt_q <= cnt_q - CW'(1);
               acc_q <= step_acc;
            end
            StFix: begin
               hi_q <= hi_fix;
               lo_q <= lo_fix;
            end
            StDone: begin
               cnt_q <= '0;
            end
            default: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: table of signed MULT/DIV vectors plus
// hand-written sequences for ignored re-starts and a mid-operation reset.
module tb_mult_div_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   mult_div_seq #(
      .WIDTH(32)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .div_zero(div_zero),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Moves to the next cycle (the IDLE slot), pulses start for one cycle,
   // then waits a bounded number of cycles for done.
   task automatic run_op(input logic o, input logic [31:0] va, input logic [31:0] vb,
                         input string tag, output int lat, output logic busy_bad,
                         output logic busy_at_done);
      @(posedge clk);
      #1;
      check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
      op    = o;
      a     = va;
      b     = vb;
      start = 1'b1;
      lat          = -1;
      busy_bad     = 1'b0;
      busy_at_done = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            start = 1'b0;
            op    = ~o;
            a     = $urandom;
            b     = $urandom;
         end
         if (done) begin
            lat          = c;
            busy_at_done = busy;
            break;
         end
         if (!busy) busy_bad = 1'b1;
      end
   endtask

   int   lat;
   logic busy_bad;
   logic busy_at_done;
   int   done_cnt;
   int   first_done;
   logic [31:0] hi_s;
   logic [31:0] lo_s;
   logic seen_done;

   initial begin
      vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
      vecs[2]  = '{1'b0, 32'd3,        32'd4,        32'h00000000, 32'd12,       1'b0, 35};
      vecs[3]  = '{1'b1, 32'd5,        32'd0,        32'h00000000, 32'd12,       1'b1, 2};
      vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
      vecs[5]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35};
      vecs[6]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
      vecs[7]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 35};
      vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0, 35};
      vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'd1,        1'b0, 35};
      vecs[10] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 35};
      vecs[11] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 35};
      vecs[12] = '{1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 35};
      vecs[13] = '{1'b1, 32'd3,        32'd5,        32'd3,        32'd0,        1'b0, 35};
      vecs[14] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 35};
      vecs[15] = '{1'b0, 32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0, 35};

      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_status", {61'd0, busy, done, div_zero}, 64'd0);
      check("reset_hi", {32'd0, hi}, 64'd0);
      check("reset_lo", {32'd0, lo}, 64'd0);
      reset = 1'b0;

      // Table-driven vectors, issued back to back
      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("v%0d", i), lat, busy_bad,
                busy_at_done);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
         check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
         check($sformatf("v%0d_div_zero", i), {63'd0, div_zero}, {63'd0, vecs[i].dz});
         check($sformatf("v%0d_busy_before_done", i), {63'd0, busy_bad}, 64'd0);
         check($sformatf("v%0d_busy_at_done", i), {63'd0, busy_at_done}, 64'd0);
      end

      // start re-pulsed with new operands in cycles 5 and 20 of a MULT
      @(posedge clk);
      #1;
      op    = 1'b0;
      a     = 32'd9;
      b     = 32'd11;
      start = 1'b1;
      done_cnt   = 0;
      first_done = -1;
      hi_s       = '0;
      lo_s       = '0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk);
         #1;
         if (c == 5 || c == 20) begin
            start = 1'b1;
            op    = 1'b1;
            a     = 32'd1000;
            b     = 32'd3;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            done_cnt++;
            if (first_done < 0) begin
               first_done = c;
               hi_s       = hi;
               lo_s       = lo;
            end
         end
      end
      check("restart_done_count", 64'(done_cnt), 64'd1);
      check("restart_latency", 64'(first_done), 64'd35);
      check("restart_hi", {32'd0, hi_s}, 64'd0);
      check("restart_lo", {32'd0, lo_s}, 64'd99);

      // reset in cycle 10 of a DIV, then a fresh DIV starting in cycle 12
      @(posedge clk);
      #1;
      op        = 1'b1;
      a         = 32'd1000;
      b         = 32'd7;
      start     = 1'b1;
      seen_done = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) seen_done = 1'b1;
      end
      check("midreset_busy_before", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      if (done) seen_done = 1'b1;
      check("midreset_status", {61'd0, busy, done, div_zero}, 64'd0);
      check("midreset_hi", {32'd0, hi}, 64'd0);
      check("midreset_lo", {32'd0, lo}, 64'd0);
      check("midreset_no_done", {63'd0, seen_done}, 64'd0);
      run_op(1'b1, 32'd1000, 32'd7, "post_reset", lat, busy_bad, busy_at_done);
      check("post_reset_latency", 64'(lat), 64'd35);
      check("post_reset_hi", {32'd0, hi}, 64'd6);
      check("post_reset_lo", {32'd0, lo}, 64'd142);
      check("post_reset_busy", {63'd0, busy_bad}, 64'd0);

      // done must be a single-cycle pulse
      @(posedge clk);
      #1;
      check("done_single_pulse", {62'd0, busy, done}, 64'd0);
      check("hold_lo", {32'd0, lo}, 64'd142);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
